// File: rtl/fifo_rd_drain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_rd_drain_pkg                                            |
// | Description : Shared types for the FIFO read-side drain engine: FSM state  |
// |               encoding and the skid-buffer entry layout.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package fifo_rd_drain_pkg;

  // Drain FSM state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    WAIT  = 2'd2
  } drain_state_t;

  // Data width of the default skid entry; matches the default FIFO word width.
  localparam int unsigned SKID_DEF_WIDTH = 8;

  // One skid-buffer entry: the word plus its end-of-burst tag.
  typedef struct packed {
    logic                      last;
    logic [SKID_DEF_WIDTH-1:0] data;
  } skid_entry_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_rd_skid                                                 |
// | Description : Two-entry in-order skid buffer that absorbs the FIFO's       |
// |               registered read latency ahead of the output stream.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   rdclk       in   FIFO read clock                                         |
// |   reset_      in   asynchronous active-low reset                           |
// |   push        in   write push_entry at the tail                            |
// |   push_entry  in   entry to store (ENTRY_T)                                |
// |   pop         in   drop the head entry (ignored when empty)                |
// |   occupancy   out  number of stored entries, 0..2                          |
// |   head        out  oldest stored entry                                     |
// +----------------------------------------------------------------------------+
module fifo_rd_skid
  import fifo_rd_drain_pkg::*;
#(
  parameter type ENTRY_T = skid_entry_t
) (
  input  logic       rdclk,
  input  logic       reset_,
  input  logic       push,
  input  ENTRY_T     push_entry,
  input  logic       pop,
  output logic [1:0] occupancy,
  output ENTRY_T     head
);

  ENTRY_T     r_mem0;   // head slot
  ENTRY_T     r_mem1;   // second slot
  logic [1:0] r_occ;
  logic       w_pop;

  assign w_pop = pop && (r_occ != 2'd0);

  always_ff @(posedge rdclk or negedge reset_) begin
    if (!reset_) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_occ  <= 2'd0;
    end else begin
      case ({push, w_pop})
        2'b10: begin
          // The upstream credit scheme never pushes into a full buffer;
          // the guard just keeps the occupancy encoding sane if it did.
          if (r_occ == 2'd0) begin
            r_mem0 <= push_entry;
            r_occ  <= 2'd1;
          end else if (r_occ == 2'd1) begin
            r_mem1 <= push_entry;
            r_occ  <= 2'd2;
          end
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_occ  <= r_occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop: occupancy is unchanged, contents shift.
          if (r_occ == 2'd1) begin
            r_mem0 <= push_entry;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= push_entry;
          end
        end
        default: begin
          r_occ <= r_occ;
        end
      endcase
    end
  end

  assign occupancy = r_occ;
  assign head      = r_mem0;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_rd_drain                                                |
// | Description : Read-side consumer for the dual-clock FIFO. Waits for a      |
// |               full burst (or a flush), issues rden pulses, absorbs the     |
// |               one-cycle dataout latency in a 2-entry skid buffer and       |
// |               presents words on a valid/ready stream with a last marker.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   rdclk         in   FIFO read clock                                       |
// |   reset_        in   asynchronous active-low reset                         |
// |   fifo_rden     out  FIFO read request                                     |
// |   fifo_dataout  in   FIFO read data, valid the cycle after fifo_rden       |
// |   fifo_rdempty  in   FIFO empty                                            |
// |   fifo_rdusedw  in   FIFO fill level (PTR+1 bits)                          |
// |   flush         in   drain a partial burst                                 |
// |   out_valid     out  stream word valid                                     |
// |   out_ready     in   downstream accepts the word                           |
// |   out_data      out  stream word                                           |
// |   out_last      out  final word of a burst                                 |
// |   busy          out  FSM not idle                                          |
// |   word_cnt      out  accepted words, wraps    (FIFO_RD_DRAIN_STATS_EN)     |
// |   burst_cnt     out  accepted last words      (FIFO_RD_DRAIN_STATS_EN)     |
// +----------------------------------------------------------------------------+
// | Build option: define FIFO_RD_DRAIN_STATS_EN to add word/burst counters.    |
// +----------------------------------------------------------------------------+
module fifo_rd_drain
  import fifo_rd_drain_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PTR       = 4,
  parameter int BURST_LEN = 4
) (
  input  logic             rdclk,
  input  logic             reset_,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_dataout,
  input  logic             fifo_rdempty,
  input  logic [PTR:0]     fifo_rdusedw,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [15:0]      word_cnt,
  output logic [15:0]      burst_cnt
`endif
);

  // Skid entry sized to this instance's word width.
  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam logic [PTR:0] c_burst_len = (PTR+1)'(BURST_LEN);
  localparam logic [PTR:0] c_one       = (PTR+1)'(1);
  localparam logic [PTR:0] c_zero      = '0;

  drain_state_t r_state;
  drain_state_t w_state_nxt;
  logic [PTR:0] r_remaining;
  logic [PTR:0] w_remaining_nxt;
  logic         r_inflight;       // rden issued last cycle; data arrives now
  logic         r_inflight_last;  // that rden took remaining 1 -> 0
  logic         w_rden;
  logic [1:0]   w_occ;
  logic [1:0]   w_used;
  logic         w_credit_ok;
  logic         w_pop;
  entry_t       w_push_entry;
  entry_t       w_head;

  // Credit counts only registered state: a pop in this cycle does not free a
  // slot until next cycle. This keeps rden off the out_ready path.
  assign w_used      = w_occ + {1'b0, r_inflight};
  assign w_credit_ok = (w_used < 2'd2);

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_rden          = 1'b0;
    case (r_state)
      IDLE: begin
        // A full burst wins over flush.
        if (fifo_rdusedw >= c_burst_len) begin
          w_state_nxt     = BURST;
          w_remaining_nxt = c_burst_len;
        end else if (flush && !fifo_rdempty) begin
          w_state_nxt     = BURST;
          w_remaining_nxt = fifo_rdusedw;
        end
      end
      BURST: begin
        w_rden = (r_remaining != c_zero) && !fifo_rdempty && w_credit_ok;
        if (w_rden) begin
          w_remaining_nxt = r_remaining - c_one;
          if (r_remaining == c_one) begin
            w_state_nxt = WAIT;
          end
        end else if (r_remaining == c_zero) begin
          // A flush that captured a zero fill level (empty flag and level
          // momentarily disagreeing) must not park the FSM here forever.
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if ((w_occ == 2'd0) && !r_inflight) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge rdclk or negedge reset_) begin
    if (!reset_) begin
      r_state         <= IDLE;
      r_remaining     <= c_zero;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_remaining     <= w_remaining_nxt;
      r_inflight      <= w_rden;
      r_inflight_last <= w_rden && (r_remaining == c_one);
    end
  end

  assign w_push_entry = '{last: r_inflight_last, data: fifo_dataout};

  fifo_rd_skid #(
    .ENTRY_T   (entry_t)
  ) u_skid (
    .rdclk     (rdclk),
    .reset_    (reset_),
    .push      (r_inflight),
    .push_entry(w_push_entry),
    .pop       (w_pop),
    .occupancy (w_occ),
    .head      (w_head)
  );

  assign fifo_rden = w_rden;
  assign out_valid = (w_occ != 2'd0);
  // Outputs read as zero while nothing is presented.
  assign out_data  = out_valid ? w_head.data : '0;
  assign out_last  = out_valid && w_head.last;
  assign w_pop     = out_valid && out_ready;
  assign busy      = (r_state != IDLE);

`ifdef FIFO_RD_DRAIN_STATS_EN
  logic [15:0] r_word_cnt;
  logic [15:0] r_burst_cnt;

  always_ff @(posedge rdclk or negedge reset_) begin
    if (!reset_) begin
      r_word_cnt  <= 16'd0;
      r_burst_cnt <= 16'd0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 16'd1;
      if (out_last) begin
        r_burst_cnt <= r_burst_cnt + 16'd1;
      end
    end
  end

  assign word_cnt  = r_word_cnt;
  assign burst_cnt = r_burst_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_rd_drain                                             |
// | Description : Self-checking bench for fifo_rd_drain with a behavioural     |
// |               FIFO read port (one-cycle registered dataout).               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fifo_rd_drain;

  logic       rdclk;
  logic       reset_;
  logic       fifo_rden;
  logic [7:0] fifo_dataout = 8'h00;
  logic       fifo_rdempty;
  logic [4:0] fifo_rdusedw;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
`ifdef FIFO_RD_DRAIN_STATS_EN
  logic [15:0] word_cnt;
  logic [15:0] burst_cnt;
`endif

  fifo_rd_drain #(
    .WIDTH       (8),
    .PTR         (4),
    .BURST_LEN   (4)
  ) dut (
    .rdclk       (rdclk),
    .reset_      (reset_),
    .fifo_rden   (fifo_rden),
    .fifo_dataout(fifo_dataout),
    .fifo_rdempty(fifo_rdempty),
    .fifo_rdusedw(fifo_rdusedw),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
`ifdef FIFO_RD_DRAIN_STATS_EN
    ,
    .word_cnt    (word_cnt),
    .burst_cnt   (burst_cnt)
`endif
  );

  initial rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  // Behavioural FIFO read port. usedw_bias lets a test report a fill level
  // ahead of the readable words to force a mid-burst empty.
  logic [7:0] mem [0:255];
  int wr_ptr     = 0;
  int rd_ptr     = 0;
  int usedw_bias = 0;

  assign fifo_rdempty = (wr_ptr == rd_ptr);
  assign fifo_rdusedw = 5'(wr_ptr - rd_ptr + usedw_bias);

  always @(posedge rdclk) begin
    if (fifo_rden) begin
      fifo_dataout <= mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Monitor: sampled on the falling edge, i.e. the values the next rising
  // edge will act on.
  int         rden_cnt       = 0;
  int         rden_empty_cnt = 0;
  int         got_wr         = 0;
  logic [7:0] got_data [0:255];
  logic       got_last [0:255];

  always @(negedge rdclk) begin
    if (reset_ === 1'b1) begin
      if (fifo_rden === 1'b1) begin
        rden_cnt = rden_cnt + 1;
        if (fifo_rdempty) rden_empty_cnt = rden_empty_cnt + 1;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_data[got_wr[7:0]] = out_data;
        got_last[got_wr[7:0]] = out_last;
        got_wr = got_wr + 1;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int got_rd   = 0;
  int rden_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rdclk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
    tick();
  endtask

  // Compare the words delivered since the last call, then consume them.
  task automatic check_words(input string name, input int n,
                             input logic [7:0][7:0] exp_d, input logic [7:0] exp_l);
    check({name, "_count"}, got_wr - got_rd, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", name, i), {24'h0, got_data[(got_rd + i) % 256]}, {24'h0, exp_d[i]});
      check($sformatf("%s_last%0d", name, i), {31'h0, got_last[(got_rd + i) % 256]}, {31'h0, exp_l[i]});
    end
    got_rd = got_wr;
  endtask

  typedef struct {
    int              n_push;
    logic [7:0]      base;
    logic            flush;
    int              n_exp;
    logic [7:0][7:0] exp_data;   // index 0 = first word out
    logic [7:0]      exp_last;   // bit i = last flag of word i
    int              exp_usedw;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1);
  end

  initial begin
    // Threshold burst leaving one word behind.
    vecs[0] = '{5, 8'h11, 1'b0, 4, {32'h0, 8'h14, 8'h13, 8'h12, 8'h11}, 8'h08, 1};
    // Flush of the single leftover word.
    vecs[1] = '{0, 8'h00, 1'b1, 1, {56'h0, 8'h15}, 8'h01, 0};
    // Flush of a 2-word partial burst.
    vecs[2] = '{2, 8'hA0, 1'b1, 2, {48'h0, 8'hA1, 8'hA0}, 8'h02, 0};
    // Below threshold, no flush: nothing moves.
    vecs[3] = '{3, 8'h30, 1'b0, 0, 64'h0, 8'h00, 3};
    // One more word reaches the threshold exactly.
    vecs[4] = '{1, 8'h40, 1'b0, 4, {32'h0, 8'h40, 8'h32, 8'h31, 8'h30}, 8'h08, 0};
    // Threshold has priority over flush: 4-word burst then 2-word flush burst.
    vecs[5] = '{6, 8'hC0, 1'b1, 6, {16'h0, 8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0}, 8'h28, 0};

    reset_    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge rdclk);
    #2;
    check("rst_rden",  {31'h0, fifo_rden}, 0);
    check("rst_valid", {31'h0, out_valid}, 0);
    check("rst_data",  {24'h0, out_data},  0);
    check("rst_last",  {31'h0, out_last},  0);
    check("rst_busy",  {31'h0, busy},      0);
    reset_ = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      rden_base = rden_cnt;
      for (int k = 0; k < vecs[v].n_push; k++) push(vecs[v].base + 8'(k));
      flush = vecs[v].flush;
      ticks(40);
      flush = 1'b0;
      tick();
      check_words($sformatf("vec%0d", v), vecs[v].n_exp, vecs[v].exp_data, vecs[v].exp_last);
      check($sformatf("vec%0d_rden", v),  rden_cnt - rden_base, vecs[v].n_exp);
      check($sformatf("vec%0d_usedw", v), {27'h0, fifo_rdusedw}, vecs[v].exp_usedw);
      check($sformatf("vec%0d_busy", v),  {31'h0, busy}, 0);
    end
    // Drain the 3-word leftover-free state check: FIFO empty now.

    // Backpressure: out_ready low for a whole 4-word burst.
    out_ready = 1'b0;
    rden_base = rden_cnt;
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
    ticks(10);
    check("bp_rden_max", rden_cnt - rden_base, 2);
    check("bp_valid",    {31'h0, out_valid}, 1);
    check("bp_busy",     {31'h0, busy}, 1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold_data%0d", i), {24'h0, out_data}, 32'hB0);
      check($sformatf("bp_hold_last%0d", i), {31'h0, out_last}, 0);
      tick();
    end
    out_ready = 1'b1;
    ticks(20);
    check_words("bp", 4, {32'h0, 8'hB3, 8'hB2, 8'hB1, 8'hB0}, 8'h08);
    check("bp_rden_total", rden_cnt - rden_base, 4);
    check("bp_busy_end",   {31'h0, busy}, 0);

    // Mid-burst empty: level reports 4 while only 2 words are readable.
    rden_base  = rden_cnt;
    usedw_bias = 2;
    push(8'hD0); push(8'hD1);
    begin
      int w = 0;
      while (!busy && w < 10) begin tick(); w++; end
    end
    check("me_start_busy", {31'h0, busy}, 1);
    usedw_bias = 0;
    ticks(10);
    check("me_stall_rden",  rden_cnt - rden_base, 2);
    check("me_stall_words", got_wr - got_rd, 2);
    check("me_stall_busy",  {31'h0, busy}, 1);
    check("me_stall_nordn", {31'h0, fifo_rden}, 0);
    push(8'hD2); push(8'hD3);
    ticks(20);
    check_words("me", 4, {32'h0, 8'hD3, 8'hD2, 8'hD1, 8'hD0}, 8'h08);
    check("me_busy_end", {31'h0, busy}, 0);

    // Asynchronous reset in the middle of a burst.
    rden_base = rden_cnt;
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    begin
      int w = 0;
      while ((rden_cnt - rden_base) < 2 && w < 20) begin tick(); w++; end
    end
    check("rm_two_reads", rden_cnt - rden_base, 2);
    check("rm_pre_busy",  {31'h0, busy}, 1);
    check("rm_pre_valid", {31'h0, out_valid}, 1);
    #1;
    reset_ = 1'b0;
    #1;
    check("rm_rden",  {31'h0, fifo_rden}, 0);
    check("rm_valid", {31'h0, out_valid}, 0);
    check("rm_data",  {24'h0, out_data},  0);
    check("rm_last",  {31'h0, out_last},  0);
    check("rm_busy",  {31'h0, busy},      0);
    ticks(2);
    reset_ = 1'b1;
    got_rd = got_wr;
    rden_base = rden_cnt;
    check("rm_left_usedw", {27'h0, fifo_rdusedw}, 2);
    push(8'h61); push(8'h62);
    ticks(25);
    check_words("rm", 4, {32'h0, 8'h62, 8'h61, 8'h54, 8'h53}, 8'h08);
    check("rm_rden_after", rden_cnt - rden_base, 4);
    check("rm_busy_end",   {31'h0, busy}, 0);

    check("rden_while_empty", rden_empty_cnt, 0);

`ifdef FIFO_RD_DRAIN_STATS_EN
    // Counters restarted at the mid-burst reset; one 4-word burst since.
    check("stats_word_cnt",  {16'h0, word_cnt},  4);
    check("stats_burst_cnt", {16'h0, burst_cnt}, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
